draw_rect_physics_ctl: RTL and testbench
========================================

// Module: draw_rect_physics_ctl
// PURPOSE
//  Position controller for the draggable rectangle, with gravity and damped bouncing.
//  - Rectangle follows the mouse until the left button releases it.
//  - It then falls, bounces with energy loss, and settles on the floor.
//  - Right button re-grabs it.
//  - Drives xpos/ypos of the rectangle draw stage; physics steps once per frame_tick (1/frame).
// PARAMETERS
//  SCREEN_W    800   visible width, px
//  SCREEN_H    600   visible height, px
//  RECT_W      48    rectangle width, px
//  RECT_H      64    rectangle height, px
//  FRAC        8     fraction bits of internal fixed-point y and velocity
//  GRAVITY     64    velocity increment per tick, units 2^-FRAC px/tick
//  V_MAX       4096  falling-velocity saturation, same units
//  V_MIN       256   post-bounce velocity below which the block settles
//  DAMP_SHIFT  2     bounce keeps vel - (vel >> DAMP_SHIFT)
// PORTS
//  clk           in   1    pixel clock
//  rst           in   1    synchronous, active-high reset
//  frame_tick    in   1    one-cycle pulse per frame; physics step enable
//  mouse_left    in   1    level; releases rectangle (HOLD only)
//  mouse_right   in   1    level; re-grab, returns to HOLD from any state
//  mouse_x       in   12   mouse x, px
//  mouse_y       in   12   mouse y, px
//  xpos          out  12   rectangle left edge, px (registered)
//  ypos          out  12   rectangle top edge, px = y_fp >> FRAC (registered)
//  state         out  2    0 HOLD, 1 FALL, 2 RISE, 3 REST
//  bounce_cnt    out  8    floor impacts since last grab, saturates at 255
// BEHAVIOUR
//  Internals and constants
//  - y_fp and vel: unsigned, 12+FRAC bits; intermediate sums 13+FRAC bits.
//  - FLOOR = SCREEN_H-RECT_H (536 default); XMAX = SCREEN_W-RECT_W (752).
//  Reset
//  - state=HOLD; xpos=ypos=0; y_fp=vel=0; bounce_cnt=0.
//  - Applies mid-operation too, overriding all other inputs.
//  Priority and timing
//  - Priority: rst > mouse_right > state logic.
//  - Any update happens at the edge sampling its cause; xpos/ypos valid after that edge.
//  HOLD (every clk)
//  - xpos=min(mouse_x,XMAX); y_fp=min(mouse_y,FLOOR)<<FRAC; vel=0.
//  - mouse_left=1: go to FALL. Position update of that same cycle still occurs; x then frozen.
//  FALL, on tick
//  - vn=min(vel+GRAVITY,V_MAX); yn=y_fp+vn.
//  - If yn>=FLOOR<<FRAC: y_fp=FLOOR<<FRAC; vd=vn-(vn>>DAMP_SHIFT); bounce_cnt++.
//    vd<V_MIN: vel=0, go to REST. Else vel=vd, go to RISE.
//  - Else y_fp=yn, vel=vn.
//  RISE, on tick
//  - vel<=GRAVITY: vel=0, go to FALL, y unchanged.
//  - Else vel-=GRAVITY, y_fp-=new vel.
//  - If the subtraction would go below 0: y_fp=0, vel=0, go to FALL.
//  REST
//  - Position frozen; frame_tick and mouse_left ignored.
//  mouse_right=1 (any non-reset state)
//  - Next state HOLD, bounce_cnt=0, vel=0; position follows mouse in that same cycle.
//  Other rules
//  - frame_tick is ignored in HOLD and REST.
//  - mouse_left is ignored outside HOLD.
//  - Simultaneous tick+mouse_right: the grab wins and no physics step occurs.
// TESTING
//  1 HOLD clamp: mouse_x=900, mouse_y=700 -> xpos=752, ypos=536, state=0.
//  2 Drop from y=0: mouse_left pulse, then 4 ticks.
//    -> vel 64,128,192,256; y_fp=640; ypos=2; state=1.
//  3 Settle: release at mouse_y=536, 1 tick.
//    -> vn=64, vd=48<256 -> state=3, ypos=536, bounce_cnt=1.
//  4 Bounce: force impact with vn=1024.
//    -> vel=768, state=2. Next tick: vel=704, y_fp=(536<<8)-704, ypos=533.
//  5 Saturation and re-grab: 80 ticks of free fall -> vel never exceeds 4096.
//    Then mouse_right with tick in the same cycle -> state=0, no step, bounce_cnt=0, xpos=mouse_x.
//  6 rst asserted mid-FALL -> next cycle state=0, xpos=ypos=0, bounce_cnt=0.

Source files
------------

// File: rtl/draw_rect_physics_ctl.sv
// rtl/draw_rect_physics_ctl.sv - drag, drop, gravity and damped-bounce position controller for the rectangle
module draw_rect_physics_ctl #(
  parameter int SCREEN_W   = 800,
  parameter int SCREEN_H   = 600,
  parameter int RECT_W     = 48,
  parameter int RECT_H     = 64,
  parameter int FRAC       = 8,
  parameter int GRAVITY    = 64,
  parameter int V_MAX      = 4096,
  parameter int V_MIN      = 256,
  parameter int DAMP_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        mouse_left,
  input  logic        mouse_right,
  input  logic [11:0] mouse_x,
  input  logic [11:0] mouse_y,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [1:0]  state,
  output logic [7:0]  bounce_cnt
);

  localparam int YW = 12 + FRAC;
  localparam int SW = YW + 1;

  localparam logic [11:0]   FLOOR    = 12'(SCREEN_H - RECT_H);
  localparam logic [11:0]   XMAX     = 12'(SCREEN_W - RECT_W);
  localparam logic [YW-1:0] FLOOR_FP = YW'((SCREEN_H - RECT_H) << FRAC);
  localparam logic [YW-1:0] GRAV     = YW'(GRAVITY);
  localparam logic [YW-1:0] VMAX     = YW'(V_MAX);
  localparam logic [YW-1:0] VMIN     = YW'(V_MIN);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    FALL = 2'd1,
    RISE = 2'd2,
    REST = 2'd3
  } state_t;

  state_t        st;
  logic [YW-1:0] y_fp;
  logic [YW-1:0] vel;

  // Mouse-follow position, clamped so the rectangle stays on screen
  logic [11:0]   x_clamp;
  logic [11:0]   y_clamp;
  logic [YW-1:0] y_hold_fp;

  assign x_clamp   = (mouse_x > XMAX)  ? XMAX  : mouse_x;
  assign y_clamp   = (mouse_y > FLOOR) ? FLOOR : mouse_y;
  assign y_hold_fp = {y_clamp, {FRAC{1'b0}}};

  // Falling step: accelerate, saturate, then test for floor contact
  logic [SW-1:0] v_sum;
  logic [YW-1:0] v_fall;
  logic [SW-1:0] y_sum;
  logic          hit_floor;
  logic [YW-1:0] v_damp;
  logic [7:0]    bcnt_inc;

  assign v_sum     = {1'b0, vel} + {1'b0, GRAV};
  assign v_fall    = (v_sum > {1'b0, VMAX}) ? VMAX : v_sum[YW-1:0];
  assign y_sum     = {1'b0, y_fp} + {1'b0, v_fall};
  assign hit_floor = (y_sum >= {1'b0, FLOOR_FP});
  assign v_damp    = v_fall - (v_fall >> DAMP_SHIFT);
  assign bcnt_inc  = (bounce_cnt == 8'hFF) ? bounce_cnt : bounce_cnt + 8'd1;

  // Rising step: decelerate, then move up by the reduced velocity
  logic [YW-1:0] v_rise;
  logic          rise_stop;
  logic          rise_under;
  logic [YW-1:0] y_rise;

  assign rise_stop  = (vel <= GRAV);
  assign v_rise     = vel - GRAV;
  assign rise_under = (y_fp < v_rise);
  assign y_rise     = y_fp - v_rise;

  assign state = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= HOLD;
      xpos       <= 12'd0;
      ypos       <= 12'd0;
      y_fp       <= '0;
      vel        <= '0;
      bounce_cnt <= 8'd0;
    end else if (mouse_right) begin
      st         <= HOLD;
      xpos       <= x_clamp;
      ypos       <= y_clamp;
      y_fp       <= y_hold_fp;
      vel        <= '0;
      bounce_cnt <= 8'd0;
    end else begin
      case (st)
        HOLD: begin
          xpos <= x_clamp;
          ypos <= y_clamp;
          y_fp <= y_hold_fp;
          vel  <= '0;
          if (mouse_left) st <= FALL;
        end
        FALL: begin
          if (frame_tick) begin
            if (hit_floor) begin
              y_fp       <= FLOOR_FP;
              ypos       <= FLOOR;
              bounce_cnt <= bcnt_inc;
              if (v_damp < VMIN) begin
                vel <= '0;
                st  <= REST;
              end else begin
                vel <= v_damp;
                st  <= RISE;
              end
            end else begin
              y_fp <= y_sum[YW-1:0];
              ypos <= y_sum[YW-1:FRAC];
              vel  <= v_fall;
            end
          end
        end
        RISE: begin
          if (frame_tick) begin
            if (rise_stop) begin
              vel <= '0;
              st  <= FALL;
            end else if (rise_under) begin
              y_fp <= '0;
              ypos <= 12'd0;
              vel  <= '0;
              st   <= FALL;
            end else begin
              vel  <= v_rise;
              y_fp <= y_rise;
              ypos <= y_rise[YW-1:FRAC];
            end
          end
        end
        REST: begin
        end
        default: st <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_rect_physics_ctl.sv
// tb/tb_draw_rect_physics_ctl.sv - directed and randomized checks of draw_rect_physics_ctl against a behavioural model
module tb_draw_rect_physics_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        mouse_left;
  logic        mouse_right;
  logic [11:0] mouse_x;
  logic [11:0] mouse_y;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [1:0]  state;
  logic [7:0]  bounce_cnt;

  always #5 clk = ~clk;

  draw_rect_physics_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .mouse_left (mouse_left),
    .mouse_right(mouse_right),
    .mouse_x    (mouse_x),
    .mouse_y    (mouse_y),
    .xpos       (xpos),
    .ypos       (ypos),
    .state      (state),
    .bounce_cnt (bounce_cnt)
  );

  localparam int FLOOR_PX = 536;
  localparam int XMAX_PX  = 752;
  localparam int ONE      = 256;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: y and velocity in 1/256 px, state as 0..3
  int m_st = 0, m_x = 0, m_y = 0, m_v = 0, m_b = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input bit r, input bit t, input bit l, input bit rr,
                            input int mx, input int my);
    int vn, vd;
    if (r) begin
      m_st = 0; m_x = 0; m_y = 0; m_v = 0; m_b = 0;
    end else if (rr) begin
      m_st = 0; m_b = 0; m_v = 0;
      m_x = imin(mx, XMAX_PX);
      m_y = imin(my, FLOOR_PX) * ONE;
    end else if (m_st == 0) begin
      m_x = imin(mx, XMAX_PX);
      m_y = imin(my, FLOOR_PX) * ONE;
      m_v = 0;
      if (l) m_st = 1;
    end else if (m_st == 1 && t) begin
      vn = imin(m_v + 64, 4096);
      if (m_y + vn >= FLOOR_PX * ONE) begin
        m_y = FLOOR_PX * ONE;
        vd  = vn - vn / 4;
        m_b = imin(m_b + 1, 255);
        if (vd < 256) begin m_v = 0; m_st = 3; end
        else begin m_v = vd; m_st = 2; end
      end else begin
        m_y = m_y + vn;
        m_v = vn;
      end
    end else if (m_st == 2 && t) begin
      if (m_v <= 64) begin
        m_v = 0; m_st = 1;
      end else begin
        m_v = m_v - 64;
        if (m_y < m_v) begin m_y = 0; m_v = 0; m_st = 1; end
        else m_y = m_y - m_v;
      end
    end
  endtask

  task automatic step(input bit r, input bit t, input bit l, input bit rr,
                      input int mx, input int my);
    rst = r; frame_tick = t; mouse_left = l; mouse_right = rr;
    mouse_x = 12'(mx); mouse_y = 12'(my);
    @(posedge clk);
    model_step(r, t, l, rr, mx & 12'hFFF, my & 12'hFFF);
    #1;
    check("xpos",  int'(xpos),       m_x);
    check("ypos",  int'(ypos),       m_y / ONE);
    check("state", int'(state),      m_st);
    check("bcnt",  int'(bounce_cnt), m_b);
  endtask

  task automatic ticks(input int n, input int mx, input int my);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, 0, mx, my);
      step(0, 0, 0, 0, mx, my);
    end
  endtask

  int prev_y;
  int max_dy;
  int dy;

  initial begin
    rst = 1'b1; frame_tick = 1'b0; mouse_left = 1'b0; mouse_right = 1'b0;
    mouse_x = 12'd0; mouse_y = 12'd0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 400, 300);
    check("rst_state", int'(state), 0);
    check("rst_xpos",  int'(xpos),  0);
    check("rst_ypos",  int'(ypos),  0);

    // Clamp while held
    step(0, 0, 0, 0, 900, 700);
    check("t1_xpos",  int'(xpos),  752);
    check("t1_ypos",  int'(ypos),  536);
    check("t1_state", int'(state), 0);

    // Drop from the top: 64+128+192+256 = 640 -> 2 px
    step(0, 0, 0, 0, 100, 0);
    step(0, 0, 1, 0, 100, 0);
    check("t2_release", int'(state), 1);
    ticks(4, 300, 300);
    check("t2_ypos",  int'(ypos),  2);
    check("t2_xfrz",  int'(xpos),  100);
    check("t2_state", int'(state), 1);

    // Release on the floor: one tick settles
    step(0, 0, 0, 1, 200, 536);
    step(0, 0, 1, 0, 200, 536);
    ticks(1, 200, 536);
    check("t3_state", int'(state),      3);
    check("t3_ypos",  int'(ypos),       536);
    check("t3_bcnt",  int'(bounce_cnt), 1);
    step(0, 1, 1, 0, 10, 10);
    check("t3_rest",  int'(state),      3);

    // Release at 502: 16th tick hits the floor with vn = 1024
    step(0, 0, 0, 1, 50, 502);
    step(0, 0, 1, 0, 50, 502);
    ticks(15, 50, 502);
    check("t4_pre", int'(state), 1);
    ticks(1, 50, 502);
    check("t4_state", int'(state),      2);
    check("t4_ypos",  int'(ypos),       536);
    check("t4_bcnt",  int'(bounce_cnt), 1);
    ticks(1, 50, 502);
    check("t4_rise_y", int'(ypos),  533);
    check("t4_rise_s", int'(state), 2);

    // Long free fall: per-tick motion never exceeds V_MAX (16 px)
    step(0, 0, 0, 1, 60, 0);
    step(0, 0, 1, 0, 60, 0);
    max_dy = 0;
    prev_y = int'(ypos);
    for (int i = 0; i < 80; i++) begin
      ticks(1, 60, 0);
      dy = int'(ypos) - prev_y;
      if (dy < 0) dy = -dy;
      if (dy > max_dy) max_dy = dy;
      prev_y = int'(ypos);
    end
    check("t5_vsat", (max_dy <= 16) ? 1 : 0, 1);
    check("t5_bounced", (int'(bounce_cnt) > 0) ? 1 : 0, 1);
    step(0, 1, 0, 1, 321, 45);
    check("t5_state", int'(state),      0);
    check("t5_bcnt",  int'(bounce_cnt), 0);
    check("t5_xpos",  int'(xpos),       321);
    check("t5_ypos",  int'(ypos),       45);

    // Reset in the middle of a fall
    step(0, 0, 1, 0, 70, 20);
    ticks(3, 70, 20);
    check("t6_pre", int'(state), 1);
    step(1, 1, 0, 1, 500, 500);
    check("t6_state", int'(state),      0);
    check("t6_xpos",  int'(xpos),       0);
    check("t6_ypos",  int'(ypos),       0);
    check("t6_bcnt",  int'(bounce_cnt), 0);

    // Randomized traffic checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 149) == 0,
           int'($urandom_range(0, 4095)),
           int'($urandom_range(0, 700)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
